pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 256, payload width in bits (>=1).
REQ-002 SHALL have parameter SKID_EN, default 1; 1 = registered in_ready with a 2-entry skid, 0 = single register with combinational in_ready.
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard every held entry (pipeline bubble).
REQ-007 SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts a payload this cycle.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-013 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
REQ-014 SHALL have port flush_cnt  output  CNT_W  flush cycles that discarded at least one valid entry, saturating.

Function
REQ-015 SHALL treat a transfer as occurring on a rising edge where valid=1 and ready=1 on the same side.
REQ-016 SHALL deliver the accepted payload at out_data with out_valid=1 exactly one cycle after acceptance when the stage was empty.
REQ-017 SHALL preserve order and never drop or duplicate a payload.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL (SKID_EN=1) implement states EMPTY (no entry), MAIN (out register valid), and FULL (out register plus skid register valid).
REQ-020 SHALL (SKID_EN=1) drive in_ready directly from a flop, equal to 1 in EMPTY and MAIN and 0 in FULL.
REQ-021 SHALL (SKID_EN=1) transition as follows: EMPTY, with an accept, goes to MAIN; MAIN, with an accept and no out transfer, goes to FULL with the payload in skid; MAIN, with an out transfer and no accept, goes to EMPTY; MAIN, with both, stays MAIN with the new payload; FULL, with an out transfer, goes to MAIN with skid moved into the out register.
REQ-022 SHALL (SKID_EN=0) drive in_ready = !out_valid || out_ready combinationally, with a single register only.
REQ-023 SHALL, on flush=1, clear every valid bit and zero out_data and skid data on that edge; an in_valid in the same cycle is ignored and no transfer is counted.
REQ-024 SHALL give flush priority over in_valid, out_ready and all state transitions.
REQ-025 SHALL drive in_ready=1 in the cycle after a flush.
REQ-026 SHALL increment stall_cnt by 1 per qualifying cycle and hold at 2^CNT_W-1.
REQ-027 SHALL increment flush_cnt when flush=1 and any entry is valid, and hold at 2^CNT_W-1.
REQ-028 SHALL not clear the counters on flush; only reset clears them.

Reset
REQ-029 SHALL, while rst=1, asynchronously force the state to EMPTY, out_valid=0, out_data=0, skid data=0, stall_cnt=0 and flush_cnt=0.
REQ-030 SHALL drive in_ready=1 for SKID_EN=1 while rst=1, and keep in_ready at its combinational value for SKID_EN=0.
REQ-031 SHALL discard a payload that is mid-transfer when rst is asserted, and accept nothing until the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover a single beat: with the stage empty, in_data=0xA5 and in_valid=1 for one cycle, out_ready=1 -> out_valid=1 and out_data=0xA5 on the next cycle only; stall_cnt=0.
REQ-033 SHALL cover backpressure (SKID_EN=1): send payloads 1, 2, 3 back-to-back with out_ready=0 -> 1 and 2 accepted, in_ready=0 after the second accept, 3 held upstream; after 4 stalled cycles, stall_cnt=4.
REQ-034 SHALL cover drain: from FULL(1,2), set out_ready=1 and in_valid=1 with payload 3 -> outputs 1, 2, 3 on consecutive cycles, no loss.
REQ-035 SHALL cover flush collision: in FULL, assert flush=1 with in_valid=1 and payload 9 -> next cycle out_valid=0, out_data=0, in_ready=1, flush_cnt=1, and 9 is never output.
REQ-036 SHALL cover saturation: with CNT_W=2, hold out_valid=1 and out_ready=0 for 6 cycles -> stall_cnt=3.
REQ-037 SHALL cover asynchronous reset: assert rst between clock edges while in MAIN -> out_valid=0 and both counters=0 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Valid/ready pipeline stage with an optional two-entry skid buffer,
// a flush input, and saturating statistics counters.
//
// Parameters
//   DATA_W  payload width in bits (>= 1)
//   SKID_EN 1: in_ready comes straight from a flop and a skid register
//              absorbs the extra beat that arrives in that cycle
//           0: one register, and in_ready = !out_valid || out_ready
//   CNT_W   statistics counter width (>= 2)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   flush      discards every held entry; takes priority over all else
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  downstream payload valid
//   out_ready  downstream accepts a payload this cycle
//   out_data   downstream payload
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
//   flush_cnt  flush cycles that discarded a valid entry, saturating
module pipe_stage_skid #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic accept;
  logic out_xfer;

  // A flush swallows any upstream beat offered in the same cycle.
  assign accept   = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      state_t            state;
      logic              ready_q;
      logic [DATA_W-1:0] skid_data;

      // ready_q is registered, so the stage must keep room for the one
      // beat that can still arrive after it decides to drop ready:
      // that beat lands in skid_data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state     <= EMPTY;
          ready_q   <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= '0;
          skid_data <= '0;
        end else if (flush) begin
          state     <= EMPTY;
          ready_q   <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= '0;
          skid_data <= '0;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                state     <= MAIN;
                out_valid <= 1'b1;
                out_data  <= in_data;
              end
            end
            MAIN: begin
              if (accept && !out_xfer) begin
                state     <= FULL;
                skid_data <= in_data;
                ready_q   <= 1'b0;
              end else if (out_xfer && !accept) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
              end else if (accept && out_xfer) begin
                out_data  <= in_data;
              end
            end
            FULL: begin
              if (out_xfer) begin
                state    <= MAIN;
                out_data <= skid_data;
                ready_q  <= 1'b1;
              end
            end
            default: begin
              state     <= EMPTY;
              ready_q   <= 1'b1;
              out_valid <= 1'b0;
            end
          endcase
        end
      end

      assign in_ready = ready_q;
    end else begin : g_single
      assign in_ready = !out_valid || out_ready;

      // Single holding register; in_ready already accounts for the
      // downstream draining it in the same cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
        end else if (out_xfer) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // The out register is always occupied whenever any entry is held,
  // so out_valid alone tells whether a flush discards something.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && out_valid && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
